// File: rtl/rx_deser_frame.sv
// rx_deser_frame
// Serial-to-parallel deserializer for the UART receive path. It sits between
// the bit-timing logic and the receive FIFO or host. Each frame is announced
// by frame_start. It collects 1..MAX_WIDTH data bits on bit_en strobes, either
// LSB- or MSB-first. It can also check a parity bit. The finished word is
// presented on a valid/ready register with overrun detection.
//
// Optional feature macro: RX_DESER_PARITY_EN
//   defined   -> parity bit state and parity check are built in
//   undefined -> no parity state; parity_en/parity_odd are ignored and
//                parity_err is tied 0
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   frame_start   one-cycle pulse starting a frame; latches configuration
//   bit_en        sample strobe; serial_in is valid in this cycle
//   serial_in     sampled serial bit
//   data_len      data bits per frame (0 or >MAX_WIDTH means MAX_WIDTH)
//   msb_first     0 = first bit is LSB, 1 = first bit is MSB
//   parity_en     one parity bit follows the data
//   parity_odd    1 = odd parity, 0 = even parity
//   p_data        assembled word, right-justified, unused upper bits 0
//   p_valid       p_data holds an unconsumed word
//   p_ready       consumer accepts the word when p_valid && p_ready
//   parity_err    parity result for the word on p_data
//   busy          a frame is being received
//   overrun       one-cycle pulse: a completed word was dropped
module rx_deser_frame #(
  parameter int MAX_WIDTH = 8,
  parameter int LEN_W     = $clog2(MAX_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic                 bit_en,
  input  logic                 serial_in,
  input  logic [LEN_W-1:0]     data_len,
  input  logic                 msb_first,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic [MAX_WIDTH-1:0] p_data,
  output logic                 p_valid,
  input  logic                 p_ready,
  output logic                 parity_err,
  output logic                 busy,
  output logic                 overrun
);

`ifdef RX_DESER_PARITY_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PARITY} state_t;
`else
  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;
`endif

  state_t               state_q, state_d;
  logic [MAX_WIDTH-1:0] shift_q, shift_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic                 msb_q, msb_d;
`ifdef RX_DESER_PARITY_EN
  logic                 par_en_q, par_en_d;
  logic                 par_odd_q, par_odd_d;
`else
  logic                 unused_parity_cfg;
`endif

  logic [MAX_WIDTH-1:0] p_data_q, p_data_d;
  logic                 p_valid_q, p_valid_d;
  logic                 perr_q, perr_d;
  logic                 overrun_q, overrun_d;

  logic [LEN_W-1:0]     len_clamped;
  logic [LEN_W-1:0]     bit_idx;
  logic                 last_bit;
  logic                 complete;
  logic                 start;
  logic                 accept;
  logic [MAX_WIDTH-1:0] word;
  logic                 word_perr;

`ifndef RX_DESER_PARITY_EN
  assign unused_parity_cfg = parity_en ^ parity_odd;
`endif

  // Out-of-range lengths collapse to the full width.
  assign len_clamped = (data_len == '0 || data_len > LEN_W'(MAX_WIDTH))
                       ? LEN_W'(MAX_WIDTH) : data_len;

  // Bits are written straight into their final position, so no shift or
  // bit reversal is needed when the word completes.
  assign bit_idx  = msb_q ? (len_q - cnt_q - LEN_W'(1)) : cnt_q;
  assign last_bit = (cnt_q == len_q - LEN_W'(1));
  assign accept   = p_valid_q && p_ready;

  // Frame FSM: bit collection, completion detection and restart.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    msb_d     = msb_q;
`ifdef RX_DESER_PARITY_EN
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
`endif
    complete  = 1'b0;
    start     = 1'b0;
    word      = shift_q;
    word_perr = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (frame_start) start = 1'b1;
      end
      ST_SHIFT: begin
        if (bit_en) begin
          for (int i = 0; i < MAX_WIDTH; i++) begin
            if (LEN_W'(i) == bit_idx) shift_d[i] = serial_in;
          end
          cnt_d = cnt_q + LEN_W'(1);
          if (last_bit) begin
`ifdef RX_DESER_PARITY_EN
            if (par_en_q) state_d = ST_PARITY;
            else
`endif
            begin
              complete = 1'b1;
              word     = shift_d;
              state_d  = ST_IDLE;
              cnt_d    = '0;
            end
          end
        end
        if (frame_start) start = 1'b1;
      end
`ifdef RX_DESER_PARITY_EN
      ST_PARITY: begin
        if (bit_en) begin
          // Data bits above len are 0, so the full-word XOR covers only
          // the received data bits.
          complete  = 1'b1;
          word      = shift_q;
          word_perr = serial_in ^ (^shift_q) ^ par_odd_q;
          state_d   = ST_IDLE;
          cnt_d     = '0;
        end
        if (frame_start) start = 1'b1;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // A frame_start discards the partial frame and any bit stored this
    // cycle. A word completing on the same edge has already been captured
    // in 'word' above.
    if (start) begin
      state_d   = ST_SHIFT;
      shift_d   = '0;
      cnt_d     = '0;
      len_d     = len_clamped;
      msb_d     = msb_first;
`ifdef RX_DESER_PARITY_EN
      par_en_d  = parity_en;
      par_odd_d = parity_odd;
`endif
    end
  end

  // Output register: load on completion if the slot is free or is being
  // emptied on this edge; otherwise drop the new word and flag overrun.
  always_comb begin
    p_data_d  = p_data_q;
    p_valid_d = p_valid_q;
    perr_d    = perr_q;
    overrun_d = 1'b0;
    if (complete) begin
      if (!p_valid_q || accept) begin
        p_data_d  = word;
        perr_d    = word_perr;
        p_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (accept) begin
      p_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      msb_q     <= 1'b0;
`ifdef RX_DESER_PARITY_EN
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
`endif
      p_data_q  <= '0;
      p_valid_q <= 1'b0;
      perr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      msb_q     <= msb_d;
`ifdef RX_DESER_PARITY_EN
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
`endif
      p_data_q  <= p_data_d;
      p_valid_q <= p_valid_d;
      perr_q    <= perr_d;
      overrun_q <= overrun_d;
    end
  end

  assign p_data     = p_data_q;
  assign p_valid    = p_valid_q;
  assign parity_err = perr_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rx_deser_frame.sv
// tb_rx_deser_frame
// Randomised and directed stimulus for rx_deser_frame with MAX_WIDTH = 8.
// Each frame's expected word is computed arithmetically from its bit list.
// A small occupancy model of the output slot decides whether the word should
// be delivered or dropped. Delivered words go into a queue. Dropped words
// record the cycle in which overrun must pulse. A monitor process drains both
// queues whenever the DUT hands over a word or raises overrun.
module tb_rx_deser_frame;

  localparam int MAX_WIDTH = 8;
  localparam int LEN_W     = 4;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             frame_start;
  logic             bit_en;
  logic             serial_in;
  logic [LEN_W-1:0] data_len;
  logic             msb_first;
  logic             parity_en;
  logic             parity_odd;
  logic [7:0]       p_data;
  logic             p_valid;
  logic             p_ready;
  logic             parity_err;
  logic             busy;
  logic             overrun;

  int   n_cmp;
  int   n_fail;
  int   cyc;
  int   ready_mode;
  bit   m_valid;
  exp_t exp_q[$];
  int   ovr_q[$];
  logic [7:0] last_word;
  bit   last_perr;

  rx_deser_frame #(.MAX_WIDTH(MAX_WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .bit_en     (bit_en),
    .serial_in  (serial_in),
    .data_len   (data_len),
    .msb_first  (msb_first),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .p_data     (p_data),
    .p_valid    (p_valid),
    .p_ready    (p_ready),
    .parity_err (parity_err),
    .busy       (busy),
    .overrun    (overrun)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle index used to time the expected overrun pulses.
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case the run never reaches its summary.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit rdy();
    case (ready_mode)
      1:       return 1'b1;
      2:       return bit'($urandom_range(0, 1));
      default: return 1'b0;
    endcase
  endfunction

  // Drive one cycle of inputs and advance the slot-occupancy model. The model
  // uses the same p_ready value that the DUT samples on the coming edge.
  task automatic applyStimulus(input bit r, input bit fs, input bit be,
                               input bit si, input bit pr, input bit cmp,
                               input logic [7:0] w, input bit pe);
    bit acc;
    rst         = r;
    frame_start = fs;
    bit_en      = be;
    serial_in   = si;
    p_ready     = pr;
    if (r) begin
      m_valid = 1'b0;
      exp_q.delete();
      ovr_q.delete();
    end else begin
      acc = m_valid && pr;
      if (cmp) begin
        if (!m_valid || acc) begin
          exp_q.push_back('{data: w, perr: pe});
          m_valid = 1'b1;
        end else begin
          ovr_q.push_back(cyc + 1);
        end
      end else if (acc) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, rdy(), 0, 8'h00, 0);
  endtask

  // Send one complete frame. bits_v[k] is the k-th bit on the wire. With
  // ready_mode 3, p_ready is low throughout the frame except in the final
  // bit cycle.
  task automatic sendFrame(input int len_in, input bit msb, input bit pen,
                           input bit podd, input logic [7:0] bits_v,
                           input bit pbit, input int gap_max, input bit chk);
    int         len;
    logic [7:0] w;
    bit         pe;
    bit         has_par;
    bit         r;
    len = (len_in == 0 || len_in > MAX_WIDTH) ? MAX_WIDTH : len_in;
    w   = 8'h00;
    for (int k = 0; k < len; k++) begin
      if (msb) w[len-1-k] = bits_v[k];
      else     w[k]       = bits_v[k];
    end
`ifdef RX_DESER_PARITY_EN
    has_par = pen;
    pe      = pen ? (pbit != ((^w) ^ podd)) : 1'b0;
`else
    has_par = 1'b0;
    pe      = 1'b0;
`endif
    last_word = w;
    last_perr = pe;

    data_len   = LEN_W'(len_in);
    msb_first  = msb;
    parity_en  = pen;
    parity_odd = podd;
    applyStimulus(0, 1, 0, 0, rdy(), 0, 8'h00, 0);
    // Configuration may change freely once latched.
    data_len   = LEN_W'($urandom_range(0, 15));
    msb_first  = bit'($urandom_range(0, 1));
    parity_en  = bit'($urandom_range(0, 1));
    parity_odd = bit'($urandom_range(0, 1));

    for (int k = 0; k < len; k++) begin
      idle($urandom_range(0, gap_max));
      if (!has_par && k == len - 1) begin
        if (chk) checkOutput("valid_before_last", 32'(p_valid), 32'd0);
        r = (ready_mode == 3) ? 1'b1 : rdy();
        applyStimulus(0, 0, 1, bits_v[k], r, 1, w, pe);
      end else begin
        applyStimulus(0, 0, 1, bits_v[k], rdy(), 0, 8'h00, 0);
      end
    end
    if (has_par) begin
      idle($urandom_range(0, gap_max));
      if (chk) checkOutput("valid_before_last", 32'(p_valid), 32'd0);
      r = (ready_mode == 3) ? 1'b1 : rdy();
      applyStimulus(0, 0, 1, pbit, r, 1, w, pe);
    end
  endtask

  initial begin
    exp_t e;
    int   oc;
    n_cmp       = 0;
    n_fail      = 0;
    cyc         = 0;
    ready_mode  = 0;
    m_valid     = 1'b0;
    rst         = 1'b1;
    frame_start = 1'b0;
    bit_en      = 1'b0;
    serial_in   = 1'b0;
    data_len    = '0;
    msb_first   = 1'b0;
    parity_en   = 1'b0;
    parity_odd  = 1'b0;
    p_ready     = 1'b0;
    last_word   = 8'h00;
    last_perr   = 1'b0;

    // Monitor: compare every handed-over word and every overrun pulse.
    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          if (p_valid && p_ready) begin
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_fail++;
              $display("[TB] FAIL unexpected_word: got 0x%0h, expected none",
                       p_data);
            end else begin
              e = exp_q.pop_front();
              checkOutput("word_data", 32'(p_data), 32'(e.data));
              checkOutput("word_perr", 32'(parity_err), 32'(e.perr));
            end
          end
          if (overrun) begin
            if (ovr_q.size() == 0) begin
              n_cmp++;
              n_fail++;
              $display("[TB] FAIL unexpected_overrun: got pulse at cycle %0d, expected none",
                       cyc);
            end else begin
              oc = ovr_q.pop_front();
              checkOutput("overrun_cycle", 32'(cyc), 32'(oc));
            end
          end
        end
      end
    join_none

    @(posedge clk);
    #1;
    applyStimulus(1, 0, 0, 0, 0, 0, 8'h00, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 8'h00, 0);
    checkOutput("reset_p_data", 32'(p_data), 32'd0);
    checkOutput("reset_p_valid", 32'(p_valid), 32'd0);
    checkOutput("reset_parity_err", 32'(parity_err), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_overrun", 32'(overrun), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 8'h00, 0);

    // len 8, LSB-first, no parity: 1,0,1,1,0,0,1,0 -> 0x4D, latency 1.
    ready_mode = 1;
    sendFrame(8, 0, 0, 0, 8'h4D, 0, 0, 1);
    checkOutput("lsb8_valid", 32'(p_valid), 32'd1);
    checkOutput("lsb8_data", 32'(p_data), 32'h4D);
    idle(2);

    // len 5, MSB-first: 1,0,0,1,1 -> 0x13.
    sendFrame(5, 1, 0, 0, 8'h19, 0, 1, 1);
    checkOutput("msb5_data", 32'(p_data), 32'h13);
    idle(2);

    // len 0 behaves as len 8.
    sendFrame(0, 0, 0, 0, 8'hC3, 0, 0, 1);
    checkOutput("len0_data", 32'(p_data), 32'hC3);
    idle(2);

    // len 7, data 0x41: even/0, even/1, odd/1.
    sendFrame(7, 0, 1, 0, 8'h41, 0, 0, 1);
    checkOutput("par_even0_err", 32'(parity_err), 32'(last_perr));
    idle(2);
    sendFrame(7, 0, 1, 0, 8'h41, 1, 1, 1);
    checkOutput("par_even1_err", 32'(parity_err), 32'(last_perr));
    idle(2);
    sendFrame(7, 0, 1, 1, 8'h41, 1, 0, 1);
    checkOutput("par_odd1_err", 32'(parity_err), 32'(last_perr));
    idle(2);

    // Overrun: 0xA5 held, second word dropped.
    ready_mode = 0;
    sendFrame(8, 0, 0, 0, 8'hA5, 0, 0, 1);
    checkOutput("hold_data", 32'(p_data), 32'hA5);
    sendFrame(8, 0, 0, 0, 8'h3C, 0, 0, 0);
    checkOutput("ovr_pulse", 32'(overrun), 32'd1);
    checkOutput("ovr_keep_data", 32'(p_data), 32'hA5);
    idle(1);
    checkOutput("ovr_one_cycle", 32'(overrun), 32'd0);
    // Accept on the completion edge: new word loads, no overrun.
    ready_mode = 3;
    sendFrame(8, 0, 0, 0, 8'h5A, 0, 1, 0);
    checkOutput("swap_data", 32'(p_data), 32'h5A);
    checkOutput("swap_valid", 32'(p_valid), 32'd1);
    checkOutput("swap_overrun", 32'(overrun), 32'd0);
    ready_mode = 1;
    idle(2);

    // Abort after 3 of 8 bits; the next full frame forms the word.
    data_len  = 4'd8;
    msb_first = 1'b0;
    applyStimulus(0, 1, 0, 0, 1, 0, 8'h00, 0);
    applyStimulus(0, 0, 1, 1, 1, 0, 8'h00, 0);
    applyStimulus(0, 0, 1, 1, 1, 0, 8'h00, 0);
    applyStimulus(0, 0, 1, 0, 1, 0, 8'h00, 0);
    checkOutput("abort_busy", 32'(busy), 32'd1);
    sendFrame(8, 0, 0, 0, 8'h96, 0, 1, 1);
    checkOutput("abort_data", 32'(p_data), 32'h96);
    idle(2);

    // Reset mid-frame with a word held.
    ready_mode = 0;
    sendFrame(8, 0, 0, 0, 8'h77, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 8'h00, 0);
    applyStimulus(0, 0, 1, 1, 0, 0, 8'h00, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 8'h00, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 8'h00, 0);
    checkOutput("rst_mid_p_data", 32'(p_data), 32'd0);
    checkOutput("rst_mid_p_valid", 32'(p_valid), 32'd0);
    checkOutput("rst_mid_parity_err", 32'(parity_err), 32'd0);
    checkOutput("rst_mid_busy", 32'(busy), 32'd0);
    checkOutput("rst_mid_overrun", 32'(overrun), 32'd0);
    ready_mode = 1;
    for (int i = 0; i < 10; i++)
      applyStimulus(0, 0, 1, bit'($urandom_range(0, 1)), 1, 0, 8'h00, 0);
    checkOutput("idle_bits_valid", 32'(p_valid), 32'd0);
    checkOutput("idle_bits_busy", 32'(busy), 32'd0);

    // Randomised frames with random back-pressure.
    ready_mode = 2;
    for (int f = 0; f < 60; f++) begin
      sendFrame(int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)),
                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                8'($urandom_range(0, 255)), bit'($urandom_range(0, 1)),
                2, 0);
      idle($urandom_range(0, 3));
    end

    ready_mode = 1;
    idle(6);
    checkOutput("words_outstanding", 32'(exp_q.size()), 32'd0);
    checkOutput("overruns_outstanding", 32'(ovr_q.size()), 32'd0);

    disable fork;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
